// File: rtl/accel_stage_sequencer.sv
// ---------------------------------------------------------------------------
// accel_stage_sequencer
//
// Runs one accelerator job as num_iter iterations of LOAD (BRAM->AXIS reader)
// followed by STORE (AXIS->BRAM writer). Holds the level-sensitive
// stage_start of each mover until its stage_done is seen, keeps both starts
// low for GAP_CYCLES cycles between stages, ping-pongs the BRAM bank select
// once per completed iteration and flags a stage that stays active too long.
//
// Ports
//   clk       in   1       clock
//   rst_n     in   1       synchronous active-low reset
//   start     in   1       job start pulse, honoured only in IDLE or ERR
//   abort     in   1       return to IDLE from any state (highest priority)
//   num_iter  in   ITER_W  iteration count, latched on an accepted start
//   ld_done   in   1       LOAD mover stage_done (level)
//   st_done   in   1       STORE mover stage_done (level)
//   ld_start  out  1       LOAD mover stage_start (level)
//   st_start  out  1       STORE mover stage_start (level)
//   buf_sel   out  1       BRAM bank used by the current iteration
//   iter_cnt  out  ITER_W  completed iterations
//   busy      out  1       job in progress (any state but IDLE / ERR)
//   done      out  1       one-cycle job-complete pulse
//   error     out  1       sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module accel_stage_sequencer #(
    parameter int ITER_W         = 8,
    parameter int GAP_CYCLES     = 2,      // 1..15
    parameter int TIMEOUT_CYCLES = 65535   // 0 disables the watchdog
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              ld_done,
    input  logic              st_done,
    output logic              ld_start,
    output logic              st_start,
    output logic              buf_sel,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    // The counter reads 0 in the first stage cycle, so the stage has been
    // active TIMEOUT_CYCLES cycles when it reads TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP_L,
        S_STORE,
        S_GAP_S,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q,    state_d;
    logic [ITER_W-1:0] num_iter_q, num_iter_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic              buf_sel_q,  buf_sel_d;
    logic              error_q,    error_d;
    logic [WD_W-1:0]   wdog_q,     wdog_d;
    logic [3:0]        gap_q,      gap_d;
    // High only in the first cycle of LOAD/STORE: the mover's done is still
    // the registered value from its previous stage there, so it is ignored.
    logic              first_q,    first_d;

    logic              timeout;

    assign timeout = WD_EN && (wdog_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        num_iter_d = num_iter_q;
        iter_cnt_d = iter_cnt_q;
        buf_sel_d  = buf_sel_q;
        error_d    = error_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        first_d    = 1'b0;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    if (num_iter != '0) begin
                        state_d    = S_LOAD;
                        num_iter_d = num_iter;
                        iter_cnt_d = '0;
                        buf_sel_d  = 1'b0;
                        error_d    = 1'b0;
                        wdog_d     = '0;
                        first_d    = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                wdog_d = wdog_q + 1'b1;
                // A genuine done wins over a timeout in the same cycle.
                if (!first_q && ld_done) begin
                    state_d = S_GAP_L;
                    gap_d   = '0;
                end else if (timeout) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_GAP_L: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_STORE;
                    wdog_d  = '0;
                    first_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_STORE: begin
                wdog_d = wdog_q + 1'b1;
                if (!first_q && st_done) begin
                    state_d    = S_GAP_S;
                    gap_d      = '0;
                    iter_cnt_d = iter_cnt_q + 1'b1;
                    buf_sel_d  = ~buf_sel_q;
                end else if (timeout) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_GAP_S: begin
                if (gap_q == GAP_LAST) begin
                    if (iter_cnt_q < num_iter_q) begin
                        state_d = S_LOAD;
                        wdog_d  = '0;
                        first_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards whatever this cycle would have done (done, timeout,
        // start) and leaves the job bookkeeping and error flag untouched.
        if (abort) begin
            state_d    = S_IDLE;
            num_iter_d = num_iter_q;
            iter_cnt_d = iter_cnt_q;
            buf_sel_d  = buf_sel_q;
            error_d    = error_q;
            first_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            num_iter_q <= '0;
            iter_cnt_q <= '0;
            buf_sel_q  <= 1'b0;
            error_q    <= 1'b0;
            wdog_q     <= '0;
            gap_q      <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_iter_q <= num_iter_d;
            iter_cnt_q <= iter_cnt_d;
            buf_sel_q  <= buf_sel_d;
            error_q    <= error_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
            first_q    <= first_d;
        end
    end

    // All outputs decode directly from registers, so they are glitch-free.
    assign ld_start = (state_q == S_LOAD);
    assign st_start = (state_q == S_STORE);
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_ERR);
    assign buf_sel  = buf_sel_q;
    assign iter_cnt = iter_cnt_q;
    assign error    = error_q;

endmodule

// File: tb/tb_accel_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_accel_stage_sequencer
//
// Directed bench for accel_stage_sequencer (GAP_CYCLES=2, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge; the DUT
// samples on the rising edge. Mover handshakes are driven step by step.
// ---------------------------------------------------------------------------
module tb_accel_stage_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] num_iter;
    logic       ld_done;
    logic       st_done;
    logic       ld_start;
    logic       st_start;
    logic       buf_sel;
    logic [7:0] iter_cnt;
    logic       busy;
    logic       done;
    logic       error;

    int vectors     = 0;
    int miscompares = 0;

    accel_stage_sequencer #(
        .ITER_W        (8),
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .num_iter(num_iter),
        .ld_done (ld_done),
        .st_done (st_done),
        .ld_start(ld_start),
        .st_start(st_start),
        .buf_sel (buf_sel),
        .iter_cnt(iter_cnt),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    // Entered at a falling edge where LOAD is expected to be active.
    task automatic do_load(input logic exp_buf);
        chk("ld_start_high", ld_start, 1);
        chk("ld_buf_sel", buf_sel, exp_buf);
        repeat (10) tick();
        ld_done = 1'b1;
        tick();
        chk("ld_start_fall", ld_start, 0);
        ld_done = 1'b0;
        chk("gap_l_1", st_start, 0);
        tick();
        chk("gap_l_2", st_start, 0);
        tick();
        chk("st_start_rise", st_start, 1);
    endtask

    // Entered at a falling edge where STORE is expected to be active.
    task automatic do_store(input logic [7:0] exp_cnt, input logic exp_buf, input bit last);
        repeat (10) tick();
        st_done = 1'b1;
        tick();
        chk("st_start_fall", st_start, 0);
        chk("iter_cnt_inc", iter_cnt, exp_cnt);
        chk("buf_sel_toggle", buf_sel, exp_buf);
        st_done = 1'b0;
        chk("gap_s_1", ld_start, 0);
        tick();
        chk("gap_s_2", ld_start, 0);
        tick();
        if (last) begin
            chk("done_pulse", done, 1);
            chk("busy_in_done", busy, 1);
            chk("no_ld_after_last", ld_start, 0);
        end else begin
            chk("ld_start_rise", ld_start, 1);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        num_iter = 8'd0;
        ld_done  = 1'b0;
        st_done  = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_ld_start", ld_start, 0);
        chk("rst_st_start", st_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_iter_cnt", iter_cnt, 0);
        chk("rst_buf_sel", buf_sel, 0);
        rst_n = 1'b1;
        tick();

        // Three-iteration job
        num_iter = 8'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("j3_busy", busy, 1);
        chk("j3_iter_clr", iter_cnt, 0);
        do_load(1'b0);
        do_store(8'd1, 1'b1, 1'b0);
        do_load(1'b1);
        do_store(8'd2, 1'b0, 1'b0);
        do_load(1'b0);
        do_store(8'd3, 1'b1, 1'b1);
        tick();
        chk("j3_done_once", done, 0);
        chk("j3_busy_fall", busy, 0);
        chk("j3_iter_final", iter_cnt, 3);
        chk("j3_buf_final", buf_sel, 1);

        // Zero-iteration job
        num_iter = 8'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("z_done", done, 1);
        chk("z_ld_start", ld_start, 0);
        chk("z_st_start", st_start, 0);
        tick();
        chk("z_done_end", done, 0);
        chk("z_busy", busy, 0);
        chk("z_ld_start_2", ld_start, 0);

        // Watchdog: ld_done never arrives
        num_iter = 8'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_ld_start", ld_start, 1);
        repeat (15) tick();
        chk("wd_not_early", ld_start, 1);
        chk("wd_err_not_early", error, 0);
        tick();
        chk("wd_error", error, 1);
        chk("wd_ld_low", ld_start, 0);
        chk("wd_busy", busy, 0);
        tick();
        chk("wd_error_sticky", error, 1);

        // Restart from ERR, then abort 5 cycles into STORE of iteration 2
        num_iter = 8'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_error_clr", error, 0);
        do_load(1'b0);
        do_store(8'd1, 1'b1, 1'b0);
        do_load(1'b1);
        repeat (4) tick();
        chk("ab_st_active", st_start, 1);
        abort   = 1'b1;
        st_done = 1'b1;
        tick();
        abort   = 1'b0;
        st_done = 1'b0;
        chk("ab_st_low", st_start, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_iter", iter_cnt, 1);
        chk("ab_buf", buf_sel, 1);
        chk("ab_error", error, 0);
        tick();
        chk("ab_no_done", done, 0);
        chk("ab_ld_low", ld_start, 0);

        // Stale ld_done at LOAD entry, and start pulse mid-job
        num_iter = 8'd2;
        start    = 1'b1;
        ld_done  = 1'b1;
        tick();
        start = 1'b0;
        chk("st_ld_start", ld_start, 1);
        tick();
        chk("stale_ignored", ld_start, 1);
        ld_done  = 1'b0;
        num_iter = 8'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_start_ld", ld_start, 1);
        chk("mid_start_iter", iter_cnt, 0);
        do_load(1'b0);
        do_store(8'd1, 1'b1, 1'b0);
        do_load(1'b1);
        do_store(8'd2, 1'b0, 1'b1);
        tick();
        chk("stale_idle", busy, 0);

        // Reset in the middle of a job
        num_iter = 8'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mr_ld_start", ld_start, 1);
        rst_n = 1'b0;
        tick();
        chk("mr_ld_low", ld_start, 0);
        chk("mr_busy", busy, 0);
        chk("mr_iter", iter_cnt, 0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
